uart_rx_cfg: RTL

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with parity, stop-bit and glitch checking
// Mid-bit sampling; a low line after a framing error never re-arms start detection.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_HALF  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic            PAR_ODD   = (PARITY == 1);
  localparam logic            PAR_EN    = (PARITY != 0);

  typedef enum logic [2:0] {
    S_WAIT_HIGH,
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q;
  logic                   sync1_q, sync2_q;
  logic [1:0]             flush_q;
  logic [CW-1:0]          clk_cnt_q;
  logic [3:0]             bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_err_q, frm_err_q;
  logic                   dv_q, par_err_out_q, frm_err_out_q;
  logic [DATA_BITS-1:0]   byte_q;
  logic                   line, bit_tick, stop_err_d;

  assign line       = sync2_q;
  assign bit_tick   = (clk_cnt_q == CNT_LAST);
  assign stop_err_d = frm_err_q | ~line;

  // The reset value of the synchronizer is not a real observation of the line,
  // so WAIT_HIGH only trusts it once both flops have been refilled from the pin.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      flush_q <= 2'b00;
    end else begin
      sync1_q <= i_RX_Serial;
      sync2_q <= sync1_q;
      flush_q <= {flush_q[0], 1'b1};
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q       <= S_WAIT_HIGH;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_err_q     <= 1'b0;
      frm_err_q     <= 1'b0;
      dv_q          <= 1'b0;
      byte_q        <= '0;
      par_err_out_q <= 1'b0;
      frm_err_out_q <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        S_WAIT_HIGH: begin
          if (flush_q[1] && line) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (!line) begin
            state_q   <= S_START;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
          end
        end
        S_START: begin
          if (line) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
          end else if (clk_cnt_q == CNT_HALF) begin
            state_q   <= S_DATA;
            clk_cnt_q <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            clk_cnt_q <= '0;
            shift_q   <= {line, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= PAR_EN ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'(1);
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            clk_cnt_q <= '0;
            par_err_q <= (((^shift_q) ^ line) != PAR_ODD);
            state_q   <= S_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            clk_cnt_q <= '0;
            if (bit_cnt_q == STOP_LAST) begin
              bit_cnt_q     <= '0;
              dv_q          <= 1'b1;
              byte_q        <= shift_q;
              par_err_out_q <= PAR_EN & par_err_q;
              frm_err_out_q <= stop_err_d;
              frm_err_q     <= stop_err_d;
              state_q       <= stop_err_d ? S_WAIT_HIGH : S_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'(1);
              frm_err_q <= stop_err_d;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        default: state_q <= S_WAIT_HIGH;
      endcase
    end
  end

  assign o_RX_DV      = dv_q;
  assign o_RX_Byte    = byte_q;
  assign o_Parity_Err = par_err_out_q;
  assign o_Frame_Err  = frm_err_out_q;
  assign o_Busy       = (state_q == S_START) || (state_q == S_DATA) ||
                        (state_q == S_PARITY) || (state_q == S_STOP);

endmodule
